// File: rtl/elevator_request_latch.sv
// Button front end for the elevator controller. Each raw button is synchronised and debounced,
// and each new press sets a sticky request that holds until the controller opens the door at that floor.
module elevator_request_latch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] f_btn,
  input  logic [2:0] u_btn,
  input  logic [2:0] d_btn,
  input  logic       open,
  input  logic [3:0] DISP,
  output logic       F1,
  output logic       F2,
  output logic       F3,
  output logic       F4,
  output logic       U1,
  output logic       U2,
  output logic       U3,
  output logic       U4,
  output logic       D1,
  output logic       D2,
  output logic       D3,
  output logic       D4,
  output logic [3:0] pending_cnt,
  output logic       any_pending
);

  // Channel order: [3:0] F1..F4, [6:4] U1..U3, [9:7] D2..D4.
  localparam int             NCH     = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   s1;
  logic [NCH-1:0]   s2;
  logic [NCH-1:0]   deb;
  logic [NCH-1:0]   deb_d;
  logic [NCH-1:0]   press;
  logic [NCH-1:0]   req;
  logic [NCH-1:0]   svc_ch;
  logic [CNT_W-1:0] cnt [NCH];
  logic [3:0]       svc_floor;
  logic [3:0]       req_count;

  assign raw = {d_btn, u_btn, f_btn};

  // Two-flop synchroniser for the asynchronous button inputs.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // A level change is accepted only once s2 has differed from deb for DEBOUNCE_CYCLES edges in a row.
  // NOTE: the counter array is reset too, because a reset must discard any partially counted debounce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < NCH; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = deb & ~deb_d;

  // A floor is serviced while the door is open and DISP shows that floor's even code.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    svc_floor = '0;
    for (int k = 0; k < 4; k++) begin
      svc_floor[k] = open && (DISP == 4'(2 * (k + 1)));
    end
  end

  assign svc_ch = {svc_floor[3:1], svc_floor[2:0], svc_floor[3:0]};

  // Service wins over a simultaneous press, so a passenger already being served is not re-latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) req <= '0;
    else       req <= (req | press) & ~svc_ch;
  end

  always_comb begin
    req_count = '0;
    for (int i = 0; i < NCH; i++) begin
      req_count = req_count + 4'(req[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_cnt <= '0;
    else       pending_cnt <= req_count;
  end

  assign any_pending = |pending_cnt;

  assign F1 = req[0];
  assign F2 = req[1];
  assign F3 = req[2];
  assign F4 = req[3];
  assign U1 = req[4];
  assign U2 = req[5];
  assign U3 = req[6];
  assign U4 = 1'b0;
  assign D1 = 1'b0;
  assign D2 = req[7];
  assign D3 = req[8];
  assign D4 = req[9];

endmodule

// File: tb/tb_elevator_request_latch.sv
// Directed bench for elevator_request_latch: latency, bounce rejection, service clearing and reset.
module tb_elevator_request_latch;

  localparam int DB = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] f_btn = '0;
  logic [2:0] u_btn = '0;
  logic [2:0] d_btn = '0;
  logic       open  = 1'b0;
  logic [3:0] DISP  = '0;
  logic F1, F2, F3, F4, U1, U2, U3, U4, D1, D2, D3, D4;
  logic [3:0] pending_cnt;
  logic       any_pending;
  logic [9:0] req_v;

  int checks = 0;
  int errors = 0;

  elevator_request_latch #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .f_btn(f_btn), .u_btn(u_btn), .d_btn(d_btn),
    .open(open), .DISP(DISP),
    .F1(F1), .F2(F2), .F3(F3), .F4(F4),
    .U1(U1), .U2(U2), .U3(U3), .U4(U4),
    .D1(D1), .D2(D2), .D3(D3), .D4(D4),
    .pending_cnt(pending_cnt), .any_pending(any_pending)
  );

  always #5 clk = ~clk;

  // Bit order: F1..F4 = [3:0], U1..U3 = [6:4], D2..D4 = [9:7].
  assign req_v = {D4, D3, D2, U3, U2, U1, F4, F3, F2, F1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    #2;
    check("reset_req", 32'(req_v), 'h000);
    check("reset_cnt", 32'(pending_cnt), 0);
    check("reset_any", 32'(any_pending), 0);
    step(1);
    reset = 1'b0;
    step(2);

    // Reset mid-run wipes latched F3 and U2.
    f_btn[2] = 1'b1;
    u_btn[1] = 1'b1;
    step(8);
    check("t1_latched", 32'(req_v), 'h024);
    #1;
    f_btn = '0;
    u_btn = '0;
    reset = 1'b1;
    #1;
    check("t1_async_req", 32'(req_v), 'h000);
    check("t1_async_cnt", 32'(pending_cnt), 0);
    check("t1_async_any", 32'(any_pending), 0);
    #2;
    reset = 1'b0;
    step(12);
    check("t1_no_return", 32'(req_v), 'h000);
    check("t1_cnt_after", 32'(pending_cnt), 0);

    // Clean press: F3 after edge 7, pending_cnt after edge 8.
    f_btn[2] = 1'b1;
    step(6);
    check("t2_f3_e6", 32'(F3), 0);
    step(1);
    check("t2_f3_e7", 32'(F3), 1);
    check("t2_cnt_e7", 32'(pending_cnt), 0);
    step(1);
    check("t2_cnt_e8", 32'(pending_cnt), 1);
    check("t2_any_e8", 32'(any_pending), 1);
    step(12);
    f_btn = '0;
    step(10);
    check("t2_sticky", 32'(req_v), 'h004);
    do_reset();

    // Bounce rejection on U1, then a real press.
    u_btn[0] = 1'b1; step(3);
    u_btn[0] = 1'b0; step(2);
    u_btn[0] = 1'b1; step(3);
    u_btn[0] = 1'b0; step(6);
    check("t3_bounce", 32'(req_v), 'h000);
    u_btn[0] = 1'b1;
    step(6);
    check("t3_u1_e6", 32'(U1), 0);
    u_btn[0] = 1'b0;
    step(1);
    check("t3_u1_e7", 32'(U1), 1);
    step(8);
    check("t3_cnt", 32'(pending_cnt), 1);
    do_reset();

    // Service at floor 2 clears F2, U2, D2 but leaves F4.
    f_btn = 4'b1010;
    u_btn = 3'b010;
    d_btn = 3'b001;
    step(8);
    f_btn = '0;
    u_btn = '0;
    d_btn = '0;
    step(8);
    check("t4_latched", 32'(req_v), 'h0AA);
    check("t4_cnt4", 32'(pending_cnt), 4);
    open = 1'b1;
    DISP = 4'd4;
    step(1);
    check("t4_cleared", 32'(req_v), 'h008);
    check("t4_cnt_lag", 32'(pending_cnt), 4);
    open = 1'b0;
    step(1);
    check("t4_cnt1", 32'(pending_cnt), 1);
    open = 1'b1;
    DISP = 4'd5;
    step(2);
    check("t4_odd_disp", 32'(req_v), 'h008);
    open = 1'b0;
    DISP = 4'd8;
    step(2);
    check("t4_closed", 32'(req_v), 'h008);
    check("t4_cnt_hold", 32'(pending_cnt), 1);
    DISP = '0;
    do_reset();

    // Press event for D3 and D4 in the same cycle as service at floor 3.
    d_btn = 3'b110;
    step(6);
    check("t5_pre", 32'(req_v), 'h000);
    open = 1'b1;
    DISP = 4'd6;
    step(1);
    open = 1'b0;
    DISP = '0;
    check("t5_d3_dropped", 32'(D3), 0);
    check("t5_d4_set", 32'(D4), 1);
    step(4);
    check("t5_hold_no_repress", 32'(D3), 0);
    d_btn = '0;
    step(8);
    check("t5_final", 32'(req_v), 'h200);
    do_reset();

    // Full load, then service floors 1..4 (floors hold 2, 3, 3, 2 request lines).
    f_btn = 4'b1111;
    u_btn = 3'b111;
    d_btn = 3'b111;
    step(8);
    f_btn = '0;
    u_btn = '0;
    d_btn = '0;
    check("t6_all", 32'(req_v), 'h3FF);
    check("t6_cnt10", 32'(pending_cnt), 10);
    check("t6_any", 32'(any_pending), 1);
    check("t6_u4_d1", 32'({U4, D1}), 0);
    step(8);
    for (int k = 1; k <= 4; k++) begin
      int exp_cnt;
      case (k)
        1:       exp_cnt = 8;
        2:       exp_cnt = 5;
        3:       exp_cnt = 2;
        default: exp_cnt = 0;
      endcase
      open = 1'b1;
      DISP = 4'(2 * k);
      step(1);
      open = 1'b0;
      DISP = '0;
      step(1);
      check($sformatf("t6_cnt_floor%0d", k), 32'(pending_cnt), 32'(exp_cnt));
      check($sformatf("t6_u4_d1_floor%0d", k), 32'({U4, D1}), 0);
    end
    check("t6_any_final", 32'(any_pending), 0);
    check("t6_req_final", 32'(req_v), 'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
